// File: rtl/dehaze_window_ctrl.sv
// Frame/window sequencer for a 3x3 dehaze datapath: IDLE -> RUN -> DRAIN -> DONE.
// Optional DEHAZE_CTRL_STATS_EN adds frame_cnt / win_cnt statistics outputs.
module dehaze_window_ctrl #(
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [$clog2(IMG_W)-1:0]   col,
    output logic [$clog2(IMG_H)-1:0]   row,
    output logic                       win_valid,
    output logic                       out_valid,
    output logic                       busy,
`ifdef DEHAZE_CTRL_STATS_EN
    output logic [15:0]                frame_cnt,
    output logic [15:0]                win_cnt,
`endif
    output logic                       done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO_C      = CW'(2);
    localparam logic [RW-1:0] TWO_R      = RW'(2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  win_valid_q, win_valid_d;
    logic [PIPE_LAT-1:0]   pipe_q, pipe_d;
    logic                  accept;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and scan position
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready = (state_q == S_RUN);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end

    assign accept = in_valid && in_ready;
    assign col    = col_q;
    assign row    = row_q;

    // A window is complete once the pixel at row>=2, col>=2 arrives
    always_comb begin
        win_valid_d = accept && (row_q >= TWO_R) && (col_q >= TWO_C);
        pipe_d      = '0;
        pipe_d[0]   = win_valid_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid_q <= 1'b0;
            pipe_q      <= '0;
        end else begin
            win_valid_q <= win_valid_d;
            pipe_q      <= pipe_d;
        end
    end

    assign win_valid = win_valid_q;
    assign out_valid = pipe_q[PIPE_LAT-1];

`ifdef DEHAZE_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] win_cnt_q, win_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        win_cnt_d   = win_cnt_q;
        if (done) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if ((state_q == S_IDLE) && start) begin
            win_cnt_d = '0;
        end else if (win_valid_q) begin
            win_cnt_d = win_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            win_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign win_cnt   = win_cnt_q;
`endif

endmodule

// File: doc/dehaze_window_ctrl.md
DEHAZE_WINDOW_CTRL -- requirements
Module: dehaze_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 16, pixels per row (>=3).
REQ-002 Parameter IMG_H, default 16, rows per frame (>=3).
REQ-003 Parameter PIPE_LAT, default 3, cycles from window-valid to result-valid in the dehaze datapath (>=1).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  frame start request, sampled in IDLE only.
REQ-007 in_valid  input  1  upstream pixel available.
REQ-008 in_ready  output  1  controller accepts a pixel; transfer occurs when in_valid && in_ready.
REQ-009 col  output  clog2(IMG_W)  column of the next pixel to accept.
REQ-010 row  output  clog2(IMG_H)  row of the next pixel to accept.
REQ-011 win_valid  output  1  a complete 3x3 window is presented to the datapath this cycle.
REQ-012 out_valid  output  1  datapath result (arg3_4/agg3_4/agb3_4) is valid this cycle.
REQ-013 busy  output  1  frame in progress (state != IDLE).
REQ-014 done  output  1  one-cycle frame-complete pulse.

Function
REQ-015 The FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE -> RUN when start=1; col and row cleared on entry.
REQ-017 in_ready SHALL be 1 only in RUN.
REQ-018 Each accepted pixel SHALL advance col; at col=IMG_W-1, col wraps to 0 and row increments.
REQ-019 With no transfer (in_valid=0), col, row and state SHALL hold.
REQ-020 win_valid SHALL be registered: high the cycle after accepting a pixel with row>=2 and col>=2; otherwise low.
REQ-021 out_valid SHALL equal win_valid delayed by exactly PIPE_LAT cycles through a shift register.
REQ-022 Accepting pixel (IMG_H-1, IMG_W-1) in cycle N SHALL move RUN -> DRAIN, with row/col wrapping to 0.
REQ-023 DRAIN SHALL last PIPE_LAT cycles; the state is DONE in cycle N+PIPE_LAT+1.
REQ-024 In DONE: done=1 for one cycle, then IDLE; the final out_valid coincides with done.
REQ-025 win_valid pulses per frame SHALL total (IMG_W-2)*(IMG_H-2).
REQ-026 start outside IDLE SHALL be ignored; start in the DONE cycle is also ignored.

Reset
REQ-027 On reset, the state SHALL go to IDLE; col, row, win_valid, out_valid, the delay line, busy, done and in_ready SHALL be 0.
REQ-028 Reset mid-frame SHALL abort it with no done pulse; pending out_valid pulses are discarded.
REQ-029 reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro DEHAZE_CTRL_STATS_EN defined: add output frame_cnt (16 bits, +1 on each done, wraps at 65535->0) and win_cnt (16 bits, win_valid pulses in the current frame, cleared on start).
REQ-031 Macro DEHAZE_CTRL_STATS_EN undefined: frame_cnt and win_cnt ports and logic SHALL be absent; all other behaviour is identical.
REQ-032 Both counters SHALL reset to 0.

Verification
REQ-033 Set IMG_W=4, IMG_H=4, PIPE_LAT=3; pulse start; hold in_valid=1 for 16 pixels -> win_valid high after pixels (2,2),(2,3),(3,2),(3,3) = 4 pulses; out_valid repeats the pattern 3 cycles later; done in cycle N+4 after the last accept.
REQ-034 Same config, in_valid toggled 1/0 -> col/row hold on 0 cycles; still 4 win_valid pulses and exactly one done.
REQ-035 Assert start in RUN, DRAIN and DONE -> no state change; next frame starts only from IDLE.
REQ-036 Assert reset after pixel (2,3) is accepted -> next cycle IDLE, all outputs 0, no done pulse, no later out_valid.
REQ-037 Assert start and reset together in IDLE -> remain IDLE, busy=0.
REQ-038 With DEHAZE_CTRL_STATS_EN, run 2 frames -> frame_cnt=2 and win_cnt=4 at each done.
